// File: rtl/ponte_memoria_dados_pkg.sv
// ponte_memoria_dados_pkg: shared state encoding, widths and helpers for the data-memory bridge.
package ponte_memoria_dados_pkg;

    localparam logic [1:0] EST_OCIOSO     = 2'd0;
    localparam logic [1:0] EST_REQUISICAO = 2'd1;
    localparam logic [1:0] EST_RESPOSTA   = 2'd2;
    localparam logic [1:0] EST_CONCLUIDO  = 2'd3;

    localparam int LARGURA_BARRAMENTO = 32;
    localparam int LARGURA_CONTADOR   = 8;

    typedef enum logic [1:0] {
        OCIOSO     = EST_OCIOSO,
        REQUISICAO = EST_REQUISICAO,
        RESPOSTA   = EST_RESPOSTA,
        CONCLUIDO  = EST_CONCLUIDO
    } estado_t;

    function automatic logic alinhado(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/ponte_memoria_dados_contador_limite.sv
// contador_limite: up-counter with synchronous clear and enable, flagging when it equals a limit.
module contador_limite
    import ponte_memoria_dados_pkg::*;
#(
    parameter int W = LARGURA_CONTADOR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         limpa_i,
    input  logic         habilita_i,
    input  logic [W-1:0] limite_i,
    output logic         atingiu_o
);

    logic [W-1:0] contagem_q, contagem_d;

    always_comb contagem_d = limpa_i ? '0 : (habilita_i ? contagem_q + 1'b1 : contagem_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) contagem_q <= '0;
        else        contagem_q <= contagem_d;
    end

    assign atingiu_o = contagem_q == limite_i;

endmodule

// File: rtl/ponte_memoria_dados.sv
// ponte_memoria_dados: bridges the core's single-cycle data-memory port to a valid/ready bus,
// stalling the pipeline until each access completes and flagging misalignment, slave errors and timeouts.
module ponte_memoria_dados
    import ponte_memoria_dados_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          le_memoria,
    input  logic                          escreve_memoria,
    input  logic [LARGURA_BARRAMENTO-1:0] endereco,
    input  logic [LARGURA_BARRAMENTO-1:0] dado_escrita,
    output logic [LARGURA_BARRAMENTO-1:0] dado_lido,
    output logic                          parada,
    output logic                          erro_acesso,
    output logic                          bus_req_valid,
    input  logic                          bus_req_ready,
    output logic                          bus_we,
    output logic [LARGURA_BARRAMENTO-1:0] bus_addr,
    output logic [LARGURA_BARRAMENTO-1:0] bus_wdata,
    input  logic                          bus_rsp_valid,
    input  logic                          bus_rsp_err,
    input  logic [LARGURA_BARRAMENTO-1:0] bus_rdata
);

    // RESPOSTA starts with the counter at 0, so matching TIMEOUT-1 gives exactly TIMEOUT cycles there.
    localparam logic [LARGURA_CONTADOR-1:0] LIMITE = LARGURA_CONTADOR'(TIMEOUT - 1);

    estado_t                       estado_q, estado_d;
    logic [LARGURA_BARRAMENTO-1:0] addr_q, addr_d, wdata_q, wdata_d, dado_q, dado_d;
    logic                          we_q, we_d, erro_q, erro_d;
    logic                          acesso, atingiu;

    assign acesso = le_memoria | escreve_memoria;

    contador_limite #(.W(LARGURA_CONTADOR)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .limpa_i   (estado_q != RESPOSTA),
        .habilita_i(estado_q == RESPOSTA),
        .limite_i  (LIMITE),
        .atingiu_o (atingiu)
    );

    always_comb begin
        estado_d = estado_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        dado_d   = dado_q;
        erro_d   = erro_q;
        unique case (estado_q)
            OCIOSO: begin
                if (acesso && alinhado(endereco[1:0])) begin
                    addr_d   = {endereco[LARGURA_BARRAMENTO-1:2], 2'b00};
                    wdata_d  = dado_escrita;
                    we_d     = escreve_memoria;
                    estado_d = REQUISICAO;
                end else if (acesso) begin
                    erro_d   = 1'b1;
                    dado_d   = escreve_memoria ? dado_q : '0;
                    estado_d = CONCLUIDO;
                end
            end
            REQUISICAO: estado_d = bus_req_ready ? RESPOSTA : REQUISICAO;
            RESPOSTA: begin
                if (bus_rsp_valid) begin
                    erro_d   = bus_rsp_err;
                    dado_d   = we_q ? dado_q : (bus_rsp_err ? '0 : bus_rdata);
                    estado_d = CONCLUIDO;
                end else if (atingiu) begin
                    erro_d   = 1'b1;
                    dado_d   = '0;
                    estado_d = CONCLUIDO;
                end
            end
            CONCLUIDO: begin
                erro_d   = 1'b0;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            dado_q   <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            dado_q   <= dado_d;
            erro_q   <= erro_d;
        end
    end

    // Valid is decoded from the state so an asynchronous reset drops it at once.
    assign bus_req_valid = estado_q == REQUISICAO;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign dado_lido     = dado_q;
    assign parada        = acesso & (estado_q != CONCLUIDO);
    assign erro_acesso   = (estado_q == CONCLUIDO) & erro_q;

endmodule

// File: tb/tb_ponte_memoria_dados.sv
// tb_ponte_memoria_dados: directed bench; a per-access timeline model drives expectations checked every cycle.
module tb_ponte_memoria_dados;

    localparam int TO = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        le_memoria = 1'b0, escreve_memoria = 1'b0;
    logic [31:0] endereco = '0, dado_escrita = '0;
    logic [31:0] dado_lido;
    logic        parada, erro_acesso;
    logic        bus_req_valid, bus_we;
    logic        bus_req_ready = 1'b0, bus_rsp_valid = 1'b0, bus_rsp_err = 1'b0;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;

    int          n_cmp = 0, n_err = 0;
    logic        chk_on = 1'b0, e_parada = 1'b0, e_valid = 1'b0, e_erro = 1'b0, e_we = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, dado_model = '0;
    int          s;
    logic [31:0] d;
    logic        e;

    always #5 clk = ~clk;

    ponte_memoria_dados #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .le_memoria     (le_memoria),
        .escreve_memoria(escreve_memoria),
        .endereco       (endereco),
        .dado_escrita   (dado_escrita),
        .dado_lido      (dado_lido),
        .parada         (parada),
        .erro_acesso    (erro_acesso),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_rsp_valid  (bus_rsp_valid),
        .bus_rsp_err    (bus_rsp_err),
        .bus_rdata      (bus_rdata)
    );

    task automatic cmp(input string n, input logic [31:0] g, input logic [31:0] x);
        n_cmp++;
        if (g !== x) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, g, x);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("parada", parada, e_parada);
            cmp("bus_req_valid", bus_req_valid, e_valid);
            cmp("erro_acesso", erro_acesso, e_erro);
            cmp("dado_lido", dado_lido, dado_model);
            if (e_valid) begin
                cmp("bus_addr", bus_addr, e_addr);
                cmp("bus_wdata", bus_wdata, e_wdata);
                cmp("bus_we", bus_we, e_we);
            end
        end
    end

    // One memory instruction: r ready-wait cycles, response w cycles after RESPOSTA entry (w<0: none).
    task automatic acesso_t(input logic le, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input int r, input int w, input logic err, input logic [31:0] rd,
                            output int stalls, output logic [31:0] got_dado, output logic got_err);
        logic        mis, fail;
        int          done;
        logic [31:0] novo;
        mis  = a[1:0] != 2'b00;
        fail = mis || w < 0 || err;
        done = mis ? 1 : (w < 0 ? 2 + r + TO : 3 + r + w);
        if (mis)        novo = wr ? dado_model : 32'h0;
        else if (w < 0) novo = 32'h0;
        else if (wr)    novo = dado_model;
        else            novo = err ? 32'h0 : rd;
        stalls   = 0;
        got_dado = '0;
        got_err  = 1'b0;
        for (int c = 0; c <= done; c++) begin
            @(posedge clk); #1;
            le_memoria      = le;
            escreve_memoria = wr;
            endereco        = a;
            dado_escrita    = wd;
            bus_req_ready   = !mis && c == 1 + r;
            bus_rsp_valid   = !mis && w >= 0 && c == 2 + r + w;
            bus_rsp_err     = bus_rsp_valid ? err : 1'b1;
            bus_rdata       = bus_rsp_valid ? rd : 32'hBAD0_BAD0;
            e_parada        = c < done;
            e_valid         = !mis && c >= 1 && c <= 1 + r;
            e_erro          = c == done && fail;
            e_addr          = a;
            e_wdata         = wd;
            e_we            = wr;
            if (c == done) dado_model = novo;
            #3;
            if (parada) stalls++;
            if (c == done) begin
                got_dado = dado_lido;
                got_err  = erro_acesso;
            end
        end
        @(posedge clk); #1;
        le_memoria      = 1'b0;
        escreve_memoria = 1'b0;
        bus_req_ready   = 1'b0;
        bus_rsp_valid   = 1'b0;
        bus_rsp_err     = 1'b0;
        e_parada        = 1'b0;
        e_valid         = 1'b0;
        e_erro          = 1'b0;
    endtask

    initial begin
        #2;
        cmp("rst_valid", bus_req_valid, 0);
        cmp("rst_we", bus_we, 0);
        cmp("rst_addr", bus_addr, 0);
        cmp("rst_wdata", bus_wdata, 0);
        cmp("rst_dado", dado_lido, 0);
        cmp("rst_erro", erro_acesso, 0);
        cmp("rst_parada", parada, 0);
        #10 rst_n = 1'b1;
        chk_on = 1'b1;

        acesso_t(1, 0, 32'h10, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, s, d, e);
        cmp("rd_stalls", s, 3); cmp("rd_dado", d, 32'hDEAD_BEEF); cmp("rd_err", e, 0);

        acesso_t(0, 1, 32'h20, 32'h1234_5678, 2, 0, 0, 32'h7777_7777, s, d, e);
        cmp("wr_stalls", s, 5); cmp("wr_dado", d, 32'hDEAD_BEEF); cmp("wr_err", e, 0);

        acesso_t(1, 0, 32'h13, 32'h0, 0, 0, 0, 32'h0, s, d, e);
        cmp("mis_stalls", s, 1); cmp("mis_dado", d, 0); cmp("mis_err", e, 1);

        acesso_t(1, 0, 32'h30, 32'h0, 1, 2, 0, 32'h5555_AAAA, s, d, e);
        cmp("rdw_stalls", s, 6); cmp("rdw_dado", d, 32'h5555_AAAA);

        acesso_t(1, 0, 32'h38, 32'h0, 0, 0, 1, 32'hFFFF_FFFF, s, d, e);
        cmp("slv_stalls", s, 3); cmp("slv_dado", d, 0); cmp("slv_err", e, 1);

        acesso_t(1, 0, 32'h3C, 32'h0, 0, 1, 0, 32'h600D_CAFE, s, d, e);
        cmp("rd2_stalls", s, 4); cmp("rd2_dado", d, 32'h600D_CAFE);

        acesso_t(1, 1, 32'h50, 32'hA5A5_A5A5, 0, 0, 0, 32'h1111_1111, s, d, e);
        cmp("both_dado", d, 32'h600D_CAFE); cmp("both_err", e, 0);

        acesso_t(0, 1, 32'h24, 32'hCAFE_BABE, 0, 0, 1, 32'h2222_2222, s, d, e);
        cmp("wrerr_dado", d, 32'h600D_CAFE); cmp("wrerr_err", e, 1);

        acesso_t(1, 0, 32'h34, 32'h0, 0, -1, 0, 32'h0, s, d, e);
        cmp("to_stalls", s, 6); cmp("to_dado", d, 0); cmp("to_err", e, 1);

        acesso_t(1, 0, 32'h44, 32'h0, 0, 0, 0, 32'h1357_9BDF, s, d, e);
        cmp("rd3_dado", d, 32'h1357_9BDF);

        chk_on = 1'b0;
        @(posedge clk); #1;
        le_memoria = 1'b1;
        endereco   = 32'h40;
        @(posedge clk); #1;
        cmp("rm_valid_before", bus_req_valid, 1);
        #2;
        rst_n      = 1'b0;
        le_memoria = 1'b0;
        #1;
        cmp("rm_valid_async", bus_req_valid, 0);
        cmp("rm_dado", dado_lido, 0);
        cmp("rm_parada", parada, 0);
        dado_model = 32'h0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b1;
        bus_rsp_err   = 1'b1;
        bus_rdata     = 32'hCAFE_0000;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        bus_rsp_err   = 1'b0;
        @(posedge clk); #1;
        cmp("stray_dado", dado_lido, 0);
        cmp("stray_err", erro_acesso, 0);

        acesso_t(1, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0BAD_F00D, s, d, e);
        cmp("post_rst_stalls", s, 3); cmp("post_rst_dado", d, 32'h0BAD_F00D); cmp("post_rst_err", e, 0);

        @(posedge clk); #1;
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ponte_memoria_dados.md
# ponte_memoria_dados

Multi-cycle bridge between the core's single-cycle data-memory port and an external valid/ready data bus. It sits directly downstream of the processor's data path. The ALU result, store data and the read/write strobes from the main control enter here. The bridge returns load data and a stall signal that freezes the PC register until the access completes. It also reports misaligned accesses and bus errors or timeouts.

## Interface
- `TIMEOUT`, 255: maximum cycles to wait for a bus response before aborting (1..255).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `le_memoria`  in  1  load request from control (level, held while `parada`=1).
- `escreve_memoria`  in  1  store request from control (level, held while `parada`=1).
- `endereco`  in  32  byte address (ALU result).
- `dado_escrita`  in  32  store data (register read port 2).
- `dado_lido`  out  32  registered load data; valid in the completion cycle.
- `parada`  out  1  combinational stall to PC and register-file write enable.
- `erro_acesso`  out  1  one-cycle pulse in the completion cycle of a failed access.
- `bus_req_valid`  out  1  request valid.
- `bus_req_ready`  in  1  request accepted when valid & ready.
- `bus_we`  out  1  1 = write, 0 = read.
- `bus_addr`  out  32  word-aligned address.
- `bus_wdata`  out  32  write data.
- `bus_rsp_valid`  in  1  response valid (reads and writes both respond).
- `bus_rsp_err`  in  1  slave error, qualified by `bus_rsp_valid`.
- `bus_rdata`  in  32  read data, qualified by `bus_rsp_valid`.

## Operation
- The state machine has four states: OCIOSO, REQUISICAO, RESPOSTA and CONCLUIDO.
- `acesso` = `le_memoria` | `escreve_memoria`.
- `parada` = `acesso` & (state != CONCLUIDO).
- **OCIOSO, `acesso`=1, `endereco[1:0]`==0:**
  - latch `bus_addr`, `bus_wdata` and `bus_we`;
  - `bus_we` = `escreve_memoria`; if both strobes are set, write wins;
  - next state REQUISICAO.
- **OCIOSO, `acesso`=1, misaligned:**
  - no bus traffic;
  - set the error flag;
  - next state CONCLUIDO.
- **REQUISICAO:**
  - `bus_req_valid`=1;
  - on `bus_req_ready`, deassert valid in the next cycle and go to RESPOSTA;
  - address, data and `bus_we` stay stable while valid is up.
- **RESPOSTA:**
  - the timeout counter increments every cycle;
  - on `bus_rsp_valid`: capture `bus_rdata` into `dado_lido` (reads only; writes leave `dado_lido` unchanged), copy `bus_rsp_err` into the error flag, go to CONCLUIDO;
  - if the counter reaches `TIMEOUT` with no response: set the error flag, set `dado_lido`=0, go to CONCLUIDO.
- **CONCLUIDO:**
  - `parada`=0 so the PC advances;
  - `erro_acesso` equals the error flag;
  - on a failed load, `dado_lido`=0;
  - the error flag and counter clear;
  - always return to OCIOSO.
- The bus must not respond before the cycle after acceptance. `bus_rsp_valid` outside RESPOSTA is ignored.
- Any request arriving in OCIOSO is treated as new. Back-to-back memory instructions therefore each stall.

## Timing
- Reset values:
  - state OCIOSO, counter 0;
  - `bus_req_valid`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0;
  - `dado_lido`=0, `erro_acesso`=0;
  - `parada` follows inputs combinationally (0 when no request).
- Minimum aligned access, zero-wait bus:
  - cycle 0 OCIOSO, `parada`=1;
  - cycle 1 REQUISICAO, accepted;
  - cycle 2 RESPOSTA, response;
  - cycle 3 CONCLUIDO, `parada`=0.
  - Total: 3 stall cycles plus 1 completion cycle.
- Each `bus_req_ready` wait cycle and each response wait cycle adds 1.
- Misaligned access: one stall cycle (OCIOSO), then CONCLUIDO.
- Timeout: RESPOSTA lasts exactly `TIMEOUT` cycles before CONCLUIDO.
- Reset mid-access: everything returns to reset values immediately. `bus_req_valid` drops asynchronously. A later stray response is ignored.

## Structure
- The shared package holds:
  - state encoding constants `EST_OCIOSO`=2'd0, `EST_REQUISICAO`=2'd1, `EST_RESPOSTA`=2'd2, `EST_CONCLUIDO`=2'd3;
  - the bus width constant (32);
  - the timeout counter width (8).
- Sub-module `contador_limite`: an 8-bit up-counter with clear, enable and an `atingiu` output (count == limit). The bridge instantiates it once for the timeout.
- At top level the bridge replaces the data memory instance. `parada` gates the PC register and `EscreveRegistrador`.

## Test plan
- **Aligned read, zero-wait:** `le_memoria`=1, `endereco`=0x0000_0010, `bus_rdata`=0xDEAD_BEEF → `bus_req_valid` in cycle 1 with `bus_addr`=0x10, `bus_we`=0; `parada`=1 for 3 cycles; `dado_lido`=0xDEAD_BEEF and `parada`=0 in cycle 3; `erro_acesso`=0.
- **Write with 2 ready-wait cycles:** `escreve_memoria`=1, `endereco`=0x20, `dado_escrita`=0x1234_5678 → `bus_addr`, `bus_wdata` and `bus_we`=1 stable for 3 valid cycles; completion at cycle 5; `dado_lido` unchanged.
- **Misaligned:** `le_memoria`=1, `endereco`=0x0000_0013 → `bus_req_valid` never asserts; `parada`=1 for 1 cycle; `erro_acesso` pulses in cycle 1 with `dado_lido`=0.
- **Timeout:** `TIMEOUT`=4, read accepted, no response → CONCLUIDO after exactly 4 RESPOSTA cycles; `erro_acesso`=1, `dado_lido`=0; next state OCIOSO.
- **Slave error:** read with `bus_rsp_err`=1 and `bus_rdata`=0xFFFF_FFFF → `erro_acesso`=1, `dado_lido`=0.
- **Reset mid-access:** `rst_n` low while in REQUISICAO → `bus_req_valid`=0 immediately; after release, a `bus_rsp_valid` pulse is ignored; the next read completes normally.
